// File: rtl/cvs_pkg.sv
// Shared defaults and helpers for the pin-check block (simple_fpga_cvs_top).
// The glitch filter is enabled by defining SIMPLE_FPGA_CVS_GLITCH_FILTER_EN.
package cvs_pkg;

  localparam int N_BITS_DEF      = 5;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int FILTER_LEN_DEF  = 4;
  localparam int DIV_HALF_DEF    = 1;

  typedef logic [N_BITS_DEF-1:0] lane_vec_t;

  // Counter width that never collapses to zero bits for small ranges.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cvs_lane_filter.sv
// One input lane: SYNC_STAGES-deep synchroniser followed by an optional
// consecutive-mismatch glitch filter (SIMPLE_FPGA_CVS_GLITCH_FILTER_EN).
module cvs_lane_filter
  import cvs_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int FILTER_LEN  = FILTER_LEN_DEF
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic                   out_q;
  logic                   out_d;

  // Plain flop chain, no logic between stages.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

`ifdef SIMPLE_FPGA_CVS_GLITCH_FILTER_EN
  localparam int CW = cnt_w(FILTER_LEN + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    out_d = out_q;
    cnt_d = cnt_q;
    if (s == out_q) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(FILTER_LEN - 1)) begin
      out_d = s;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
      out_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      out_q <= out_d;
    end
  end
`else
  assign out_d = s;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      out_q <= 1'b0;
    end else begin
      out_q <= out_d;
    end
  end
`endif

  assign q_o = out_q;

endmodule

// File: rtl/simple_fpga_cvs_top.sv
// FPGA bring-up check: resynchronised, optionally glitch-filtered lane outputs
// plus a 50%-duty divided clock. Filter build: SIMPLE_FPGA_CVS_GLITCH_FILTER_EN.
module simple_fpga_cvs_top
  import cvs_pkg::*;
#(
  parameter int N_BITS      = N_BITS_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int FILTER_LEN  = FILTER_LEN_DEF,
  parameter int DIV_HALF    = DIV_HALF_DEF
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [N_BITS-1:0] in,
  output logic [N_BITS-1:0] out,
  output logic              clk_out
);

  localparam int DW = cnt_w(DIV_HALF);

  if (N_BITS < 1 || SYNC_STAGES < 2 || FILTER_LEN < 1 || DIV_HALF < 1) begin : g_param_check
    $error("simple_fpga_cvs_top: parameter below its minimum");
  end

  for (genvar i = 0; i < N_BITS; i++) begin : g_lane
    cvs_lane_filter #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILTER_LEN  (FILTER_LEN)
    ) u_lane (
      .clk_i   (clock),
      .rst_n_i (reset_n),
      .d_i     (in[i]),
      .q_o     (out[i])
    );
  end

  logic [DW-1:0] dcnt_q;
  logic [DW-1:0] dcnt_d;
  logic          clk_q;
  logic          clk_d;

  // Toggle every DIV_HALF cycles; first rise lands on the DIV_HALF-th edge out of reset.
  always_comb begin
    dcnt_d = dcnt_q + DW'(1);
    clk_d  = clk_q;
    if (dcnt_q == DW'(DIV_HALF - 1)) begin
      dcnt_d = '0;
      clk_d  = ~clk_q;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      dcnt_q <= '0;
      clk_q  <= 1'b0;
    end else begin
      dcnt_q <= dcnt_d;
      clk_q  <= clk_d;
    end
  end

  assign clk_out = clk_q;

endmodule

// File: tb/tb_simple_fpga_cvs_top.sv
// Directed + scoreboard bench for simple_fpga_cvs_top (two instances: DIV_HALF=1 and 3).
module tb_simple_fpga_cvs_top;
  import cvs_pkg::*;

  localparam int NB  = 5;
  localparam int SS  = 2;
  localparam int FL  = 4;
  localparam int DHA = 1;
  localparam int DHB = 3;
`ifdef SIMPLE_FPGA_CVS_GLITCH_FILTER_EN
  localparam int LAT = SS + FL - 1;
  localparam logic SHORT_PASSES = 1'b0;
`else
  localparam int LAT = SS;
  localparam logic SHORT_PASSES = 1'b1;
`endif

  logic      clock = 1'b0;
  logic      reset_n;
  lane_vec_t in_v;
  lane_vec_t out_a;
  lane_vec_t out_b;
  logic      clk_a;
  logic      clk_b;

  always #5 clock = ~clock;

  simple_fpga_cvs_top #(.N_BITS(NB), .SYNC_STAGES(SS), .FILTER_LEN(FL), .DIV_HALF(DHA)) u_dut_a (
    .clock(clock), .reset_n(reset_n), .in(in_v), .out(out_a), .clk_out(clk_a));

  simple_fpga_cvs_top #(.N_BITS(NB), .SYNC_STAGES(SS), .FILTER_LEN(FL), .DIV_HALF(DHB)) u_dut_b (
    .clock(clock), .reset_n(reset_n), .in(in_v), .out(out_b), .clk_out(clk_b));

  typedef struct {
    lane_vec_t o;
    logic      ca;
    logic      cb;
  } exp_t;

  exp_t      sbq[$];
  int        n_cmp = 0;
  int        n_err = 0;

  lane_vec_t m_sync[SS];
  lane_vec_t m_out;
  int        m_run[NB];
  int        m_k;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference behaviour for one posedge, using the inputs currently driven.
  task automatic model_edge();
    lane_vec_t s;
    if (!reset_n) begin
      for (int j = 0; j < SS; j++) m_sync[j] = '0;
      for (int l = 0; l < NB; l++) m_run[l] = 0;
      m_out = '0;
      m_k   = 0;
    end else begin
      s = m_sync[SS-1];
`ifdef SIMPLE_FPGA_CVS_GLITCH_FILTER_EN
      for (int l = 0; l < NB; l++) begin
        if (s[l] != m_out[l]) begin
          m_run[l]++;
          if (m_run[l] == FL) begin
            m_out[l] = s[l];
            m_run[l] = 0;
          end
        end else begin
          m_run[l] = 0;
        end
      end
`else
      m_out = s;
`endif
      for (int j = SS - 1; j > 0; j--) m_sync[j] = m_sync[j-1];
      m_sync[0] = in_v;
      m_k++;
    end
  endtask

  task automatic step(input string tag);
    exp_t e;
    model_edge();
    e.o  = m_out;
    e.ca = ((m_k / DHA) % 2) == 1;
    e.cb = ((m_k / DHB) % 2) == 1;
    sbq.push_back(e);
    @(posedge clock);
    #1;
    e = sbq.pop_front();
    chk({tag, ".out_a"}, 32'(out_a), 32'(e.o));
    chk({tag, ".out_b"}, 32'(out_b), 32'(e.o));
    chk({tag, ".clk_a"}, 32'(clk_a), 32'(e.ca));
    chk({tag, ".clk_b"}, 32'(clk_b), 32'(e.cb));
  endtask

  task automatic settle(input int n);
    for (int i = 0; i < n; i++) step("settle");
  endtask

  initial begin
    int   first_a;
    int   first_b;
    logic saw;

    reset_n = 1'b0;
    in_v    = 5'b10101;
    for (int i = 0; i < 3; i++) begin
      step("reset");
      chk("reset.out", 32'(out_a), 32'h0);
      chk("reset.clk", 32'(clk_a), 32'h0);
    end

    reset_n = 1'b1;
    for (int i = 1; i <= LAT + 1; i++) begin
      step("release");
      chk("release.out", 32'(out_a), (i >= LAT + 1) ? 32'h15 : 32'h0);
    end

    in_v = 5'b00000;
    settle(LAT + 3);
    in_v = 5'b00001;
    for (int i = 1; i <= LAT + 2; i++) begin
      step("latency");
      chk("latency.bit0", 32'(out_a[0]), (i >= LAT + 1) ? 32'h1 : 32'h0);
      chk("latency.others", 32'(out_a[4:1]), 32'h0);
    end

    in_v = 5'b00000;
    settle(LAT + 3);
    saw  = 1'b0;
    in_v = 5'b00100;
    for (int i = 0; i < 3; i++) begin step("glitch3"); saw |= out_a[2]; end
    in_v = 5'b00000;
    for (int i = 0; i < LAT + 3; i++) begin step("glitch3"); saw |= out_a[2]; end
    chk("glitch3.seen", 32'(saw), 32'(SHORT_PASSES));

    saw  = 1'b0;
    in_v = 5'b00100;
    for (int i = 0; i < 4; i++) begin step("pulse4"); saw |= out_a[2]; end
    in_v = 5'b00000;
    for (int i = 0; i < LAT + 3; i++) begin step("pulse4"); saw |= out_a[2]; end
    chk("pulse4.seen", 32'(saw), 32'h1);

    in_v = 5'b11111;
    for (int i = 1; i <= LAT + 1; i++) begin
      step("simul.rise");
      chk("simul.rise", 32'(out_a), (i >= LAT + 1) ? 32'h1f : 32'h0);
    end
    in_v = 5'b11101;
    for (int i = 1; i <= LAT + 1; i++) begin
      step("simul.fall1");
      chk("simul.fall1", 32'(out_a), (i >= LAT + 1) ? 32'h1d : 32'h1f);
    end

    in_v = 5'b00000;
    settle(LAT + 3);
    in_v = 5'b01000;
    for (int i = 0; i < 4; i++) step("midrst.pre");
    reset_n = 1'b0;
    step("midrst");
    chk("midrst.out", 32'(out_a), 32'h0);
    chk("midrst.clk_a", 32'(clk_a), 32'h0);
    chk("midrst.clk_b", 32'(clk_b), 32'h0);
    reset_n = 1'b1;
    first_a = 0;
    first_b = 0;
    for (int i = 1; i <= LAT + 2; i++) begin
      step("midrst.recount");
      chk("midrst.bit3", 32'(out_a[3]), (i >= LAT + 1) ? 32'h1 : 32'h0);
      if (first_a == 0 && clk_a) first_a = i;
      if (first_b == 0 && clk_b) first_b = i;
    end
    chk("div.first_rise_a", 32'(first_a), 32'd1);
    chk("div.first_rise_b", 32'(first_b), 32'd3);

    for (int i = 0; i < 40; i++) begin
      in_v = lane_vec_t'($urandom_range(0, 31));
      step("random");
    end
    for (int i = 0; i < 20; i++) begin
      in_v = ~in_v;
      step("toggle");
    end
    in_v = 5'b01110;
    settle(LAT + 3);
    chk("final.out", 32'(out_a), 32'h0e);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
